// File: rtl/led_matrix_pkg.sv
// Shared defaults, width helpers and pixel indexing for the LED matrix scan controller.
package led_matrix_pkg;

    localparam int unsigned DEF_ROWS         = 8;
    localparam int unsigned DEF_COLS         = 8;
    localparam int unsigned DEF_DWELL_LOG2   = 5;
    localparam int unsigned DEF_BLANK_CYCLES = 2;
    localparam int unsigned DEF_BRIGHT_W     = 3;

    // Pin edges are ignored for this many cycles after reset is released.
    localparam int unsigned EDGE_GUARD_CYCLES = 3;
    localparam int unsigned GUARD_W           = 2;

    function automatic int unsigned n_pix_of(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

    function automatic int unsigned cnt_w_of(input int unsigned rows, input int unsigned cols);
        return $clog2(rows * cols + 1);
    endfunction

    function automatic int unsigned col_w_of(input int unsigned cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int unsigned pix_index(input int unsigned col, input int unsigned row,
                                              input int unsigned rows);
        return col * rows + row;
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_pin_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, producing a one-cycle rising-edge
// pulse that stays suppressed for a short guard window after reset.
module pin_sync_edge
    import led_matrix_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise
);

    logic               meta_q,  meta_d;
    logic               sync_q,  sync_d;
    logic               prev_q,  prev_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic               guard_done;

    always_comb begin
        meta_d     = pin;
        sync_d     = meta_q;
        prev_d     = sync_q;
        guard_done = (guard_q == GUARD_W'(EDGE_GUARD_CYCLES));
        guard_d    = guard_done ? guard_q : guard_q + 1'b1;
        rise       = sync_q & ~prev_q & guard_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            guard_q <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            guard_q <= guard_d;
        end
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// LED matrix column scanner: serial frame load into a shift chain, double-buffered
// latch on strobe, column scan with dead-time blanking and global PWM brightness.
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned COLS         = DEF_COLS,
    parameter int unsigned DWELL_LOG2   = DEF_DWELL_LOG2,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int unsigned BRIGHT_W     = DEF_BRIGHT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    input  logic                dclk,
    input  logic                strobe,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic                scan_en,
    output logic [ROWS-1:0]     row_out,
    output logic [COLS-1:0]     col_sel,
    output logic                frame_start,
    output logic                frame_err
);

    localparam int unsigned N_PIX = n_pix_of(ROWS, COLS);
    localparam int unsigned CNT_W = cnt_w_of(ROWS, COLS);
    localparam int unsigned COL_W = col_w_of(COLS);

    logic                  din_meta_q, din_meta_d;
    logic                  din_s_q,    din_s_d;
    logic                  dclk_rise,  strobe_rise;
    logic [N_PIX-1:0]      chain_q,    chain_d;
    logic [N_PIX-1:0]      vbuf_q,     vbuf_d;
    logic [CNT_W-1:0]      bit_count_q, bit_count_d;
    logic                  frame_err_q, frame_err_d;
    logic [DWELL_LOG2-1:0] phase_q,    phase_d;
    logic [COL_W-1:0]      col_q,      col_d;
    logic [ROWS-1:0]       row_out_q,  row_out_d;
    logic [COLS-1:0]       col_sel_q,  col_sel_d;
    logic                  frame_start_q, frame_start_d;
    logic                  bit_count_full;
    logic                  active;

    pin_sync_edge u_dclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (dclk),
        .rise  (dclk_rise)
    );

    pin_sync_edge u_strobe_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (strobe),
        .rise  (strobe_rise)
    );

    always_comb begin
        din_meta_d     = din;
        din_s_d        = din_meta_q;
        chain_d        = chain_q;
        vbuf_d         = vbuf_q;
        bit_count_d    = bit_count_q;
        frame_err_d    = frame_err_q;
        bit_count_full = (bit_count_q == CNT_W'(N_PIX));

        if (dclk_rise) begin
            chain_d = {chain_q[N_PIX-2:0], din_s_q};
        end

        // A strobe coinciding with a shift latches the pre-shift chain and
        // counts that shift as the first bit of the next frame.
        if (strobe_rise) begin
            vbuf_d      = chain_q;
            frame_err_d = !bit_count_full;
            bit_count_d = dclk_rise ? CNT_W'(1) : '0;
        end else if (dclk_rise && !bit_count_full) begin
            bit_count_d = bit_count_q + 1'b1;
        end
    end

    always_comb begin
        phase_d = '0;
        col_d   = '0;
        if (scan_en) begin
            phase_d = phase_q + 1'b1;
            if (phase_q == '1) begin
                col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
            end else begin
                col_d = col_q;
            end
        end

        // The top BRIGHT_W bits of phase pick the PWM slot within the dwell.
        active = scan_en
              && (phase_q >= DWELL_LOG2'(BLANK_CYCLES))
              && (phase_q[DWELL_LOG2-1 -: BRIGHT_W] <= brightness);

        col_sel_d = '0;
        row_out_d = '0;
        if (active) begin
            col_sel_d[col_q] = 1'b1;
            row_out_d        = vbuf_q[pix_index(32'(col_q), 0, ROWS) +: ROWS];
        end

        frame_start_d = scan_en && (col_q == '0) && (phase_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta_q    <= 1'b0;
            din_s_q       <= 1'b0;
            chain_q       <= '0;
            vbuf_q        <= '0;
            bit_count_q   <= '0;
            frame_err_q   <= 1'b0;
            phase_q       <= '0;
            col_q         <= '0;
            row_out_q     <= '0;
            col_sel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            din_meta_q    <= din_meta_d;
            din_s_q       <= din_s_d;
            chain_q       <= chain_d;
            vbuf_q        <= vbuf_d;
            bit_count_q   <= bit_count_d;
            frame_err_q   <= frame_err_d;
            phase_q       <= phase_d;
            col_q         <= col_d;
            row_out_q     <= row_out_d;
            col_sel_q     <= col_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_out     = row_out_q;
    assign col_sel     = col_sel_q;
    assign frame_start = frame_start_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench for led_matrix_scan_ctrl: a cycle-level reference model predicts
// every output cycle from pin activity and scan settings; a monitor compares.
module tb_led_matrix_scan_ctrl;

  localparam int unsigned ROWS       = 8;
  localparam int unsigned COLS       = 8;
  localparam int unsigned DWELL_LOG2 = 5;
  localparam int unsigned BLANK      = 2;
  localparam int unsigned BRIGHT_W   = 3;
  localparam int unsigned N          = ROWS * COLS;
  localparam int unsigned DWELL      = 1 << DWELL_LOG2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                din = 1'b0;
  logic                dclk = 1'b0;
  logic                strobe = 1'b0;
  logic [BRIGHT_W-1:0] brightness = '1;
  logic                scan_en = 1'b0;
  logic [ROWS-1:0]     row_out;
  logic [COLS-1:0]     col_sel;
  logic                frame_start;
  logic                frame_err;

  led_matrix_scan_ctrl #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .DWELL_LOG2   (DWELL_LOG2),
    .BLANK_CYCLES (BLANK),
    .BRIGHT_W     (BRIGHT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .dclk        (dclk),
    .strobe      (strobe),
    .brightness  (brightness),
    .scan_en     (scan_en),
    .row_out     (row_out),
    .col_sel     (col_sel),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic            fs;
    logic            err;
  } exp_t;

  typedef struct packed {
    logic [31:0] due;
    logic        is_strobe;
    logic        dbit;
  } act_t;

  exp_t         exp_q[$];
  act_t         act_q[$];
  bit           hist[$];
  logic [N-1:0] m_vbuf;
  bit           m_err;
  int unsigned  m_cnt, since, scan_t, n_pass, n_total, cyc;
  bit           p_dclk, p_strobe;

  // Reference model: pin rises act 3 clocks after the pin changes, none within
  // 3 cycles of reset release; scan position follows from cycles since scan_en rose.
  always @(posedge clk) begin
    exp_t        e;
    act_t        a;
    bit          do_dclk, do_strobe, dbit;
    int unsigned c, ph;
    e = '0;
    if (reset) begin
      hist.delete();
      act_q.delete();
      m_vbuf   = '0;
      m_err    = 1'b0;
      m_cnt    = 0;
      since    = 0;
      scan_t   = 0;
      p_dclk   = 1'b0;
      p_strobe = 1'b0;
    end else begin
      since++;
      if (scan_en) begin
        c  = (scan_t / DWELL) % COLS;
        ph = scan_t % DWELL;
        if (ph >= BLANK && (ph >> (DWELL_LOG2 - BRIGHT_W)) <= brightness) begin
          e.col = COLS'(1) << c;
          e.row = m_vbuf[c*ROWS +: ROWS];
        end
        e.fs = (c == 0) && (ph == 0);
        scan_t++;
      end else begin
        scan_t = 0;
      end
      do_dclk = 1'b0; do_strobe = 1'b0; dbit = 1'b0;
      while (act_q.size() > 0 && act_q[0].due == since) begin
        a = act_q.pop_front();
        if (a.is_strobe) do_strobe = 1'b1;
        else begin do_dclk = 1'b1; dbit = a.dbit; end
      end
      if (since > 3) begin
        if (do_strobe) begin
          for (int unsigned j = 0; j < N; j++)
            m_vbuf[j] = (j < hist.size()) ? hist[hist.size()-1-j] : 1'b0;
          m_err = (m_cnt < N);
          m_cnt = 0;
        end
        if (do_dclk) begin
          hist.push_back(dbit);
          if (hist.size() > N) void'(hist.pop_front());
          m_cnt++;
        end
      end
      e.err = m_err;
      if (dclk && !p_dclk) begin
        a.due = since + 2; a.is_strobe = 1'b0; a.dbit = din;
        act_q.push_back(a);
      end
      if (strobe && !p_strobe) begin
        a.due = since + 2; a.is_strobe = 1'b1; a.dbit = 1'b0;
        act_q.push_back(a);
      end
      p_dclk   = dclk;
      p_strobe = strobe;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if ({row_out, col_sel, frame_start, frame_err} !== e)
        $display("FAIL cycle %0d: got row_out=%h col_sel=%h frame_start=%b frame_err=%b, required row_out=%h col_sel=%h frame_start=%b frame_err=%b",
                 cyc, row_out, col_sel, frame_start, frame_err, e.row, e.col, e.fs, e.err);
      else
        n_pass++;
      cyc++;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    n_total++;
    if (row_out !== '0 || col_sel !== '0 || frame_start !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset state: row_out=%h col_sel=%h frame_start=%b frame_err=%b, required all 0",
               row_out, col_sel, frame_start, frame_err);
    else
      n_pass++;
  endtask

  task automatic wait_frame_start(input int unsigned max_cyc);
    bit seen;
    seen = 1'b0;
    for (int unsigned k = 0; k < max_cyc && !seen; k++) begin
      tick(1);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen)
      $display("FAIL wait for frame_start expired after %0d cycles", max_cyc);
    else
      n_pass++;
  endtask

  task automatic send_bit(input logic b);
    din  = b;
    dclk = 1'b1;
    tick(2);
    dclk = 1'b0;
    tick(2);
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(2);
  endtask

  // Bits go out highest pixel index first so a full frame lands index-aligned.
  task automatic send_frame(input logic [N-1:0] f, input int unsigned len);
    for (int unsigned i = 0; i < len; i++)
      send_bit(i < N ? f[N-1-i] : 1'($urandom));
  endtask

  task automatic reset_with_dclk_high();
    dclk  = 1'b1;
    reset = 1'b1;
    tick(4);
    check_reset_state();
    reset = 1'b0;
    tick(6);
    dclk = 1'b0;
    tick(3);
  endtask

  logic [N-1:0] frame;

  initial begin
    tick(1);
    reset_with_dclk_high();

    frame = '0;
    frame[N-1] = 1'b1;
    send_frame(frame, N);
    pulse_strobe();
    brightness = 3'd7;
    tick(6);
    scan_en = 1'b1;
    tick(2 * DWELL * COLS);

    scan_en = 1'b0;
    tick(1);
    scan_en = 1'b1;
    tick(3 * DWELL + 10);
    scan_en = 1'b0;
    tick(20);
    scan_en = 1'b1;
    tick(DWELL * COLS + 40);

    send_frame('1, N);
    pulse_strobe();
    brightness = 3'd0;
    tick(DWELL * COLS);
    brightness = 3'd3;
    tick(DWELL * COLS);

    frame = {$urandom, $urandom};
    send_frame(frame, N - 1);
    pulse_strobe();
    tick(8);
    send_frame(frame, N);
    pulse_strobe();
    tick(8);

    send_frame({$urandom, $urandom}, 10);
    din    = 1'b1;
    dclk   = 1'b1;
    strobe = 1'b1;
    tick(2);
    dclk   = 1'b0;
    strobe = 1'b0;
    tick(2);
    send_frame({$urandom, $urandom}, N - 1);
    pulse_strobe();
    tick(DWELL * COLS);

    send_frame({$urandom, $urandom}, N + 6);
    pulse_strobe();
    tick(20);

    for (int unsigned r = 0; r < 6; r++) begin
      send_frame({$urandom, $urandom}, $urandom_range(N - 2, N + 2));
      pulse_strobe();
      brightness = BRIGHT_W'($urandom);
      scan_en    = ($urandom_range(0, 3) != 0);
      tick($urandom_range(50, 300));
    end

    send_frame({$urandom, $urandom}, 20);
    reset_with_dclk_high();
    brightness = 3'd7;
    send_frame({$urandom, $urandom}, N);
    pulse_strobe();
    scan_en = 1'b1;
    tick(DWELL * COLS + 8);
    wait_frame_start(2 * DWELL * COLS);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
